// File: rtl/psa_pkg.sv
// Shared defaults and FSM state encoding for the pattern-search accelerator.
// Build option PSA_WILDCARD_EN (see psa_symbol_match) enables match-any pattern symbols.
package psa_pkg;

  localparam int PSA_ADDR_W = 8;
  localparam int PSA_DATA_W = 8;
  localparam int PSA_LEN_W  = 8;
  localparam logic [7:0] PSA_WILDCARD = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_FETCH   = 3'd2,
    S_COMPARE = 3'd3,
    S_HIT     = 3'd4,
    S_DONE    = 3'd5
  } psa_state_t;

endpackage

// File: rtl/psa_symbol_match.sv
// Combinational symbol comparator for the search engine.
// With PSA_WILDCARD_EN defined, a pattern symbol equal to WILDCARD matches any block symbol.
module psa_symbol_match
  import psa_pkg::*;
#(
  parameter int                 DATA_W   = PSA_DATA_W,
  parameter logic [DATA_W-1:0]  WILDCARD = DATA_W'(PSA_WILDCARD)
) (
  input  logic [DATA_W-1:0] pat,
  input  logic [DATA_W-1:0] blk,
  output logic              eq
);

`ifdef PSA_WILDCARD_EN
  // Wildcard only counts on the pattern side; a wildcard in the block must match literally.
  assign eq = (pat == blk) || (pat == WILDCARD);
`else
  logic unused_wildcard;
  assign unused_wildcard = ^WILDCARD;
  assign eq = (pat == blk);
`endif

endmodule

// File: rtl/psa_search_engine.sv
// Pattern-search core: scans a block RAM for a pattern RAM, pausing at each hit until resumed.
// Wildcard pattern symbols are available when built with PSA_WILDCARD_EN.
//
// state   | meaning
// IDLE    | waiting for start after reset
// CHECK   | validate pl/bl, prepare first fetch
// FETCH   | RAM addresses presented, waiting for read data
// COMPARE | compare pattern and block symbol
// HIT     | match reported on found, wait for resume
// DONE    | search finished, wait for start
module psa_search_engine
  import psa_pkg::*;
#(
  parameter int                ADDR_W   = PSA_ADDR_W,
  parameter int                DATA_W   = PSA_DATA_W,
  parameter int                LEN_W    = PSA_LEN_W,
  parameter logic [DATA_W-1:0] WILDCARD = DATA_W'(PSA_WILDCARD)
) (
  input  logic              CLK100MHZ,
  input  logic              reset_n,
  input  logic              start,
  input  logic              resume,
  input  logic [ADDR_W-1:0] p,
  input  logic [LEN_W-1:0]  pl,
  input  logic [ADDR_W-1:0] b,
  input  logic [LEN_W-1:0]  bl,
  output logic [ADDR_W-1:0] pat_addr,
  input  logic [DATA_W-1:0] pat_data,
  output logic [ADDR_W-1:0] blk_addr,
  input  logic [DATA_W-1:0] blk_data,
  output logic              busy,
  output logic              found_valid,
  output logic [ADDR_W-1:0] found,
  output logic              done,
  output logic [LEN_W-1:0]  match_count
);

  psa_state_t        state;
  logic [ADDR_W-1:0] p_r;
  logic [ADDR_W-1:0] b_r;
  logic [LEN_W-1:0]  pl_r;
  logic [LEN_W-1:0]  bl_r;
  logic [LEN_W-1:0]  pcount;
  logic [LEN_W-1:0]  bcount;

  logic              sym_eq;
  logic [LEN_W-1:0]  pcount_inc;
  logic [LEN_W-1:0]  bcount_inc;
  logic [LEN_W:0]    span;
  logic              last_pos;
  logic              last_sym;
  logic [ADDR_W-1:0] blk_base;

  psa_symbol_match #(
    .DATA_W   (DATA_W),
    .WILDCARD (WILDCARD)
  ) u_match (
    .pat (pat_data),
    .blk (blk_data),
    .eq  (sym_eq)
  );

  assign pcount_inc = pcount + LEN_W'(1);
  assign bcount_inc = bcount + LEN_W'(1);
  // One extra bit so bl-pl and bcount+1 never wrap in the end-of-block test.
  assign span       = {1'b0, bl_r} - {1'b0, pl_r};
  assign last_pos   = ({1'b0, bcount} + (LEN_W+1)'(1)) > span;
  assign last_sym   = (pcount == (pl_r - LEN_W'(1)));
  assign blk_base   = b_r + ADDR_W'(bcount);

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      p_r         <= '0;
      b_r         <= '0;
      pl_r        <= '0;
      bl_r        <= '0;
      pcount      <= '0;
      bcount      <= '0;
      pat_addr    <= '0;
      blk_addr    <= '0;
      busy        <= 1'b0;
      found_valid <= 1'b0;
      found       <= '0;
      done        <= 1'b0;
      match_count <= '0;
    end else if (start) begin
      state       <= S_CHECK;
      p_r         <= p;
      b_r         <= b;
      pl_r        <= pl;
      bl_r        <= bl;
      pcount      <= '0;
      bcount      <= '0;
      busy        <= 1'b0;
      found_valid <= 1'b0;
      done        <= 1'b0;
      match_count <= '0;
    end else begin
      case (state)
        S_IDLE: ;
        S_CHECK: begin
          pcount <= '0;
          bcount <= '0;
          if ((pl_r == '0) || (pl_r > bl_r)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state    <= S_FETCH;
            busy     <= 1'b1;
            pat_addr <= p_r;
            blk_addr <= b_r;
          end
        end
        S_FETCH: begin
          state <= S_COMPARE;
        end
        S_COMPARE: begin
          if (sym_eq && last_sym) begin
            state       <= S_HIT;
            busy        <= 1'b0;
            found_valid <= 1'b1;
            found       <= blk_base;
            if (match_count != '1)
              match_count <= match_count + LEN_W'(1);
          end else if (sym_eq) begin
            state    <= S_FETCH;
            pcount   <= pcount_inc;
            pat_addr <= p_r + ADDR_W'(pcount_inc);
            blk_addr <= blk_base + ADDR_W'(pcount_inc);
          end else begin
            pcount <= '0;
            bcount <= bcount_inc;
            if (last_pos) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= S_FETCH;
              pat_addr <= p_r;
              blk_addr <= b_r + ADDR_W'(bcount_inc);
            end
          end
        end
        S_HIT: begin
          if (resume) begin
            found_valid <= 1'b0;
            pcount      <= '0;
            bcount      <= bcount_inc;
            if (last_pos) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_FETCH;
              busy     <= 1'b1;
              pat_addr <= p_r;
              blk_addr <= b_r + ADDR_W'(bcount_inc);
            end
          end
        end
        S_DONE: ;
        default: begin
          state       <= S_IDLE;
          busy        <= 1'b0;
          found_valid <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psa_search_engine.sv
// Directed self-checking bench for psa_search_engine with behavioural 1-cycle-latency RAMs.
module tb_psa_search_engine;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       resume;
  logic [7:0] p;
  logic [7:0] pl;
  logic [7:0] b;
  logic [7:0] bl;
  logic [7:0] pat_addr;
  logic [7:0] pat_data;
  logic [7:0] blk_addr;
  logic [7:0] blk_data;
  logic       busy;
  logic       found_valid;
  logic [7:0] found;
  logic       done;
  logic [7:0] match_count;

  logic [7:0] pat_mem [256];
  logic [7:0] blk_mem [256];

  int checks;
  int failures;

  psa_search_engine dut (
    .CLK100MHZ   (clk),
    .reset_n     (reset_n),
    .start       (start),
    .resume      (resume),
    .p           (p),
    .pl          (pl),
    .b           (b),
    .bl          (bl),
    .pat_addr    (pat_addr),
    .pat_data    (pat_data),
    .blk_addr    (blk_addr),
    .blk_data    (blk_data),
    .busy        (busy),
    .found_valid (found_valid),
    .found       (found),
    .done        (done),
    .match_count (match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    pat_data <= pat_mem[pat_addr];
    blk_data <= blk_mem[blk_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setup(input logic [7:0] pp, input logic [7:0] ppl,
                       input logic [7:0] bb, input logic [7:0] bbl);
    p = pp; pl = ppl; b = bb; bl = bbl;
  endtask

  // Called at a negedge; returns at the negedge after the second posedge (CHECK done).
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_resume();
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
  endtask

  task automatic wait_event(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (found_valid || done) break;
      @(negedge clk);
    end
    check({tag, "_reached"}, {31'd0, (found_valid | done)}, 32'd1);
  endtask

  task automatic load_t1();
    blk_mem[0] = 8'h41; blk_mem[1] = 8'h42; blk_mem[2] = 8'h43; blk_mem[3] = 8'h41;
    blk_mem[4] = 8'h42; blk_mem[5] = 8'h41; blk_mem[6] = 8'h42; blk_mem[7] = 8'h00;
    pat_mem[0] = 8'h41; pat_mem[1] = 8'h42;
  endtask

  int fv_cycles;
  int fv_seen;

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0; start = 1'b0; resume = 1'b0;
    p = '0; pl = '0; b = '0; bl = '0;
    for (int i = 0; i < 256; i++) begin
      pat_mem[i] = 8'h00;
      blk_mem[i] = 8'h00;
    end
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fv", {31'd0, found_valid}, 32'd0);
    check("rst_pat_addr", {24'd0, pat_addr}, 32'd0);
    check("rst_mc", {24'd0, match_count}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Test 1: three hits at 0, 3, 5
    load_t1();
    setup(8'd0, 8'd2, 8'd0, 8'd8);
    pulse_start();
    check("t1_busy_fetch", {31'd0, busy}, 32'd1);
    check("t1_blk_addr0", {24'd0, blk_addr}, 32'd0);
    wait_event("t1_hit0");
    check("t1_fv0", {31'd0, found_valid}, 32'd1);
    check("t1_found0", {24'd0, found}, 32'd0);
    check("t1_mc1", {24'd0, match_count}, 32'd1);
    check("t1_busy_hit", {31'd0, busy}, 32'd0);
    pulse_resume();
    wait_event("t1_hit1");
    check("t1_found3", {24'd0, found}, 32'd3);
    check("t1_mc2", {24'd0, match_count}, 32'd2);
    pulse_resume();
    wait_event("t1_hit2");
    check("t1_found5", {24'd0, found}, 32'd5);
    pulse_resume();
    wait_event("t1_end");
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_fv_end", {31'd0, found_valid}, 32'd0);
    check("t1_mc3", {24'd0, match_count}, 32'd3);
    check("t1_found_kept", {24'd0, found}, 32'd5);

    // Test 2: degenerate lengths
    setup(8'd0, 8'd0, 8'd0, 8'd8);
    pulse_start();
    check("t2a_done", {31'd0, done}, 32'd1);
    check("t2a_fv", {31'd0, found_valid}, 32'd0);
    check("t2a_mc", {24'd0, match_count}, 32'd0);
    setup(8'd0, 8'd9, 8'd0, 8'd8);
    pulse_start();
    check("t2b_done", {31'd0, done}, 32'd1);
    check("t2b_fv", {31'd0, found_valid}, 32'd0);
    check("t2b_busy", {31'd0, busy}, 32'd0);

    // Test 3: block wraps past the top of memory
    blk_mem[8'hFE] = 8'h00; blk_mem[8'hFF] = 8'h41;
    blk_mem[8'h00] = 8'h42; blk_mem[8'h01] = 8'h00;
    setup(8'd0, 8'd2, 8'hFE, 8'd4);
    pulse_start();
    wait_event("t3_hit");
    check("t3_fv", {31'd0, found_valid}, 32'd1);
    check("t3_found", {24'd0, found}, 32'h0FF);
    check("t3_mc", {24'd0, match_count}, 32'd1);
    pulse_resume();
    wait_event("t3_end");
    check("t3_done", {31'd0, done}, 32'd1);
    check("t3_mc_end", {24'd0, match_count}, 32'd1);

    // Test 4: async reset during COMPARE, then restart mid-search
    load_t1();
    setup(8'd0, 8'd2, 8'd0, 8'd8);
    pulse_start();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t4_rst_busy", {31'd0, busy}, 32'd0);
    check("t4_rst_found", {24'd0, found}, 32'd0);
    check("t4_rst_addr", {16'd0, pat_addr, blk_addr}, 32'd0);
    check("t4_rst_flags", {30'd0, done, found_valid}, 32'd0);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_idle", {29'd0, busy, done, found_valid}, 32'd0);
    pulse_start();
    wait_event("t4_hit0");
    check("t4_found0", {24'd0, found}, 32'd0);
    pulse_resume();
    wait_event("t4_hit1");
    check("t4_found3", {24'd0, found}, 32'd3);
    pulse_start();
    check("t4_mc_cleared", {24'd0, match_count}, 32'd0);
    wait_event("t4_rehit");
    check("t4_refound0", {24'd0, found}, 32'd0);
    check("t4_remc", {24'd0, match_count}, 32'd1);

    // Test 6: resume held high -> one HIT cycle per match
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    resume = 1'b1;
    fv_cycles = 0;
    fv_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (found_valid) fv_cycles++;
      if (done) break;
    end
    resume = 1'b0;
    check("t6_done", {31'd0, done}, 32'd1);
    check("t6_fv_cycles", fv_cycles, 32'd3);
    check("t6_mc", {24'd0, match_count}, 32'd3);
    check("t6_found", {24'd0, found}, 32'd5);

    // Test 5: wildcard pattern symbol
    pat_mem[0] = 8'h41; pat_mem[1] = 8'h3F; pat_mem[2] = 8'h41;
    blk_mem[0] = 8'h41; blk_mem[1] = 8'h42; blk_mem[2] = 8'h41;
    setup(8'd0, 8'd3, 8'd0, 8'd3);
    pulse_start();
    wait_event("t5_end");
`ifdef PSA_WILDCARD_EN
    check("t5_fv", {31'd0, found_valid}, 32'd1);
    check("t5_found", {24'd0, found}, 32'd0);
    check("t5_mc", {24'd0, match_count}, 32'd1);
`else
    check("t5_done", {31'd0, done}, 32'd1);
    check("t5_mc", {24'd0, match_count}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
